// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding
// and the word-index to byte-address helper.
package loader_pkg;

  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_LOAD  = 2'd1;
  localparam logic [1:0] LD_WRITE = 2'd2;
  localparam logic [1:0] LD_RUN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = LD_IDLE,
    ST_LOAD  = LD_LOAD,
    ST_WRITE = LD_WRITE,
    ST_RUN   = LD_RUN
  } ld_state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs successive bytes little-endian into a 32-bit word; lane index wraps
// after lane 3 so the next word starts at bits 7:0.
module byte_packer (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last_lane
);

  logic [1:0] idx;
  logic [1:0] idx_d;
  logic       idx_en;

  // clear wins over load so an aborted partial word never advances the index
  assign idx_en = clear | load;
  assign idx_d  = clear ? 2'd0 : idx + 2'd1;

  reg_arstn_en #(.W(2)) u_idx (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (idx_en),
    .d      (idx_d),
    .q      (idx)
  );

  for (genvar i = 0; i < 4; i++) begin : g_lane
    reg_arstn_en #(.W(8)) u_lane (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (load & ~clear & (idx == 2'(i))),
      .d      (data),
      .q      (word[8*i +: 8])
    );
  end

  assign last_lane = (idx == 2'd3);

endmodule

// File: rtl/reg_arstn_en.sv
// Generic register cell: asynchronous active-low reset, synchronous enable.
module reg_arstn_en #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit words, writes them to instruction
// memory, then enables the CPU until halt.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          MAX_WORDS = 512,
  parameter int          CNT_W     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             halt,
  input  logic             s_valid,
  input  logic [7:0]       s_byte,
  output logic             s_ready,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic             cpu_enable,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  ld_state_t        state, state_nxt;
  logic [CNT_W-1:0] count, wcnt, wcnt_inc;
  logic             hs, last_lane, start_zero, start_over, start_ok;
  logic [31:0]      word;

  assign hs         = s_valid & (state == ST_LOAD);
  assign start_zero = (word_count == '0);
  assign start_over = (word_count > MAX_CNT);
  assign start_ok   = (state == ST_IDLE) & start & ~halt & ~start_zero & ~start_over;
  assign wcnt_inc   = wcnt + CNT_W'(1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    wen_ext    = 1'b0;
    cpu_enable = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !halt) begin
          if (start_zero)       state_nxt = ST_RUN;
          else if (!start_over) state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (hs && last_lane) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        wen_ext   = 1'b1;
        busy      = 1'b1;
        state_nxt = (wcnt_inc == count) ? ST_RUN : ST_LOAD;
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (halt) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) & start & ~halt & start_over;
      if (start_ok) begin
        count <= word_count;
        wcnt  <= '0;
      end else if (state == ST_WRITE) begin
        wcnt <= wcnt_inc;
      end
    end
  end

  // the packer only moves in LOAD, so its word is stable throughout WRITE
  byte_packer u_packer (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     ((state == ST_IDLE) | halt),
    .load      (hs),
    .data      (s_byte),
    .word      (word),
    .last_lane (last_lane)
  );

  assign addr_ext  = word_addr(BASE_ADDR, 30'(wcnt));
  assign wdata_ext = word;
  assign ren_ext   = 1'b0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x0 and 0x100) share
// stimulus; a transaction-level model is compared against both every cycle.
module tb_imem_loader;

  localparam logic [31:0] BASE_A = 32'h0;
  localparam logic [31:0] BASE_B = 32'h100;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       s_valid = 1'b0;
  logic [9:0] word_count = '0;
  logic [7:0] s_byte = '0;

  logic        s_ready_a, wen_a, ren_a, cpu_en_a, busy_a, err_a;
  logic [31:0] addr_a, wdata_a;
  logic        s_ready_b, wen_b, ren_b, cpu_en_b, busy_b, err_b;
  logic [31:0] addr_b, wdata_b;

  int checks = 0;
  int errors = 0;
  int wen_cycles = 0;
  logic [63:0] log_a[$];
  logic [63:0] log_b[$];

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(512), .CNT_W(10), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .arst_n(arst_n), .start(start), .word_count(word_count), .halt(halt),
    .s_valid(s_valid), .s_byte(s_byte), .s_ready(s_ready_a), .addr_ext(addr_a),
    .wen_ext(wen_a), .ren_ext(ren_a), .wdata_ext(wdata_a), .cpu_enable(cpu_en_a),
    .busy(busy_a), .err(err_a)
  );

  imem_loader #(.MAX_WORDS(512), .CNT_W(10), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .arst_n(arst_n), .start(start), .word_count(word_count), .halt(halt),
    .s_valid(s_valid), .s_byte(s_byte), .s_ready(s_ready_b), .addr_ext(addr_b),
    .wen_ext(wen_b), .ren_ext(ren_b), .wdata_ext(wdata_b), .cpu_enable(cpu_en_b),
    .busy(busy_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a loader is either idle, collecting bytes for a word, holding a
  // complete word for its one write cycle, or running the CPU.
  bit          m_active = 0;
  bit          m_pending = 0;
  bit          m_run = 0;
  bit          m_err = 0;
  int          m_total = 0;
  int          m_widx = 0;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_word = '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_active = 0; m_pending = 0; m_run = 0; m_err = 0;
      m_widx = 0; m_bytes.delete();
    end else begin
      bit err_n;
      err_n = 0;
      if (halt) begin
        m_active = 0; m_pending = 0; m_run = 0; m_bytes.delete();
      end else if (m_run) begin
        m_run = 1;
      end else if (!m_active) begin
        if (start) begin
          if (word_count == 0) m_run = 1;
          else if (int'(word_count) > 512) err_n = 1;
          else begin
            m_active = 1; m_total = int'(word_count); m_widx = 0; m_bytes.delete();
          end
        end
      end else if (m_pending) begin
        m_pending = 0;
        m_widx++;
        if (m_widx == m_total) begin
          m_active = 0; m_run = 1;
        end
      end else if (s_valid) begin
        m_bytes.push_back(s_byte);
        if (m_bytes.size() == 4) begin
          m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          m_pending = 1;
        end
      end
      m_err = err_n;
    end
  end

  always @(negedge clk) begin
    chk("s_ready_a", 32'(s_ready_a), 32'(m_active && !m_pending));
    chk("s_ready_b", 32'(s_ready_b), 32'(m_active && !m_pending));
    chk("wen_a", 32'(wen_a), 32'(m_pending));
    chk("wen_b", 32'(wen_b), 32'(m_pending));
    chk("busy_a", 32'(busy_a), 32'(m_active));
    chk("busy_b", 32'(busy_b), 32'(m_active));
    chk("cpu_en_a", 32'(cpu_en_a), 32'(m_run));
    chk("cpu_en_b", 32'(cpu_en_b), 32'(m_run));
    chk("err_a", 32'(err_a), 32'(m_err));
    chk("err_b", 32'(err_b), 32'(m_err));
    chk("ren_a", 32'(ren_a), 32'h0);
    chk("ren_b", 32'(ren_b), 32'h0);
    if (m_pending) begin
      chk("addr_a", addr_a, BASE_A + 32'(4 * m_widx));
      chk("addr_b", addr_b, BASE_B + 32'(4 * m_widx));
      chk("wdata_a", wdata_a, m_word);
      chk("wdata_b", wdata_b, m_word);
    end
    if (wen_a) begin
      wen_cycles++;
      log_a.push_back({addr_a, wdata_a});
    end
    if (wen_b) log_b.push_back({addr_b, wdata_b});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int wc);
    start = 1'b1;
    word_count = 10'(wc);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    done = 0;
    s_valid = 1'b1;
    s_byte = b;
    for (int k = 0; k < 20 && !done; k++) begin
      if (s_ready_a) done = 1;
      tick();
    end
    s_valid = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout byte=%h", b);
    end
    repeat (gap) tick();
  endtask

  task automatic chk_write(input string name, input int idx, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [31:0] ed);
    chk({name, "_cnt"}, 32'(log_a.size() > idx && log_b.size() > idx), 32'h1);
    if (log_a.size() > idx && log_b.size() > idx) begin
      chk({name, "_addr_a"}, log_a[idx][63:32], ea);
      chk({name, "_addr_b"}, log_b[idx][63:32], eb);
      chk({name, "_data"}, log_a[idx][31:0], ed);
    end
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
    wen_cycles = 0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2 arst_n = 1'b0;
    #1;
    chk("rst_addr_a", addr_a, 32'h0);
    chk("rst_addr_b", addr_b, 32'h100);
    chk("rst_wdata", wdata_a, 32'h0);
    chk("rst_outs", {26'h0, s_ready_a, wen_a, ren_a, cpu_en_a, busy_a, err_a}, 32'h0);
    repeat (2) tick();
    arst_n = 1'b1;
    repeat (2) tick();

    // basic load
    clear_logs();
    do_start(2);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    chk("basic_wen_last", 32'(wen_a), 32'h1);
    chk("basic_addr_last", addr_a, 32'h4);
    tick();
    chk("basic_cpu_en", 32'(cpu_en_a), 32'h1);
    chk("basic_wen_off", 32'(wen_a), 32'h0);
    chk("basic_nwrites", 32'(log_a.size()), 32'd2);
    chk_write("basic_w0", 0, 32'h0, 32'h100, 32'h44332211);
    chk_write("basic_w1", 1, 32'h4, 32'h104, 32'h88776655);
    do_halt();
    chk("halt_cpu_en", 32'(cpu_en_a), 32'h0);

    // gappy stream
    clear_logs();
    do_start(2);
    send_byte(8'h11, 3); send_byte(8'h22, 3); send_byte(8'h33, 3); send_byte(8'h44, 3);
    send_byte(8'h55, 3); send_byte(8'h66, 3); send_byte(8'h77, 3); send_byte(8'h88, 3);
    chk("gappy_wen_cycles", 32'(wen_cycles), 32'd2);
    chk_write("gappy_w0", 0, 32'h0, 32'h100, 32'h44332211);
    chk_write("gappy_w1", 1, 32'h4, 32'h104, 32'h88776655);
    do_halt();

    // zero count
    clear_logs();
    do_start(0);
    chk("zero_cpu_en", 32'(cpu_en_a), 32'h1);
    tick(); tick();
    chk("zero_nwrites", 32'(wen_cycles), 32'd0);
    do_halt();

    // over-range, then start together with halt
    clear_logs();
    do_start(513);
    chk("over_err", 32'(err_a), 32'h1);
    tick();
    chk("over_err_drop", 32'(err_a), 32'h0);
    chk("over_idle", 32'(busy_a | cpu_en_a), 32'h0);
    halt = 1'b1;
    do_start(513);
    chk("halt_start_err", 32'(err_a), 32'h0);
    halt = 1'b0;
    do_start(512);
    chk("max_count_busy", 32'(busy_a), 32'h1);
    do_halt();
    chk("over_nwrites", 32'(wen_cycles), 32'd0);

    // abort after two bytes, then fresh single-word load
    clear_logs();
    do_start(1);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    do_halt();
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_nwrites", 32'(wen_cycles), 32'd0);
    do_start(1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    tick();
    chk_write("abort_w0", 0, 32'h0, 32'h100, 32'hDDCCBBAA);
    chk("abort_cpu_en", 32'(cpu_en_a), 32'h1);

    // asynchronous reset while running
    #2 arst_n = 1'b0;
    #1;
    chk("arst_cpu_en_a", 32'(cpu_en_a), 32'h0);
    chk("arst_cpu_en_b", 32'(cpu_en_b), 32'h0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    tick();
    clear_logs();
    do_start(1);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    tick();
    chk_write("post_rst_w0", 0, 32'h0, 32'h100, 32'h04030201);
    do_halt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the `cpu` top. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It writes those words into instruction memory through the CPU's external port (`addr_ext`/`wen_ext`/`wdata_ext`), then raises `cpu_enable` to start execution. It holds the CPU stalled until loading completes and returns it to stall on `halt`.

## Interface
- `MAX_WORDS`, 512: instruction-memory capacity in words; largest legal `word_count`.
- `CNT_W`, 10: width of `word_count`; must satisfy 2^CNT_W > MAX_WORDS.
- `BASE_ADDR`, 32'h0: byte address of the first word written.
- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `word_count`  in  CNT_W  number of words to load; latched on accepted `start`.
- `halt`  in  1  level; stops the CPU or aborts a load, returning to IDLE.
- `s_valid`  in  1  byte on `s_byte` is valid.
- `s_byte`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `addr_ext`  out  32  byte address to instruction memory.
- `wen_ext`  out  1  instruction-memory write strobe.
- `ren_ext`  out  1  held at 0.
- `wdata_ext`  out  32  packed word.
- `cpu_enable`  out  1  drives the CPU `enable` input.
- `busy`  out  1  high in LOAD or WRITE.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, LOAD, WRITE, RUN. Encoding is 2 bits: IDLE=0, LOAD=1, WRITE=2, RUN=3.
- **IDLE**
  - `start` with 0 < `word_count` ≤ MAX_WORDS: latch the count, clear the word counter and byte index, go to LOAD.
  - `start` with `word_count`==0: go directly to RUN.
  - `start` with `word_count` > MAX_WORDS: stay in IDLE and pulse `err` for one cycle.
- **LOAD**
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) stores `s_byte` into byte lane `idx` (first byte → bits 7:0), then `idx++`.
  - The handshake on lane 3 moves to WRITE; `idx` wraps to 0.
- **WRITE** (exactly one cycle)
  - `s_ready`=0, `wen_ext`=1.
  - `addr_ext` = BASE_ADDR + 4·`wcnt`; `wdata_ext` = the packed word.
  - Then `wcnt++`. If the new `wcnt`==latched count, go to RUN; otherwise go to LOAD.
- **RUN**
  - `cpu_enable`=1; remains until `halt`, which returns to IDLE.
- `halt` overrides in every state: next state is IDLE and any partial word is discarded (no write).
- `start` outside IDLE is ignored without an `err` pulse.
- Outside WRITE: `wen_ext`=0. `addr_ext`/`wdata_ext` hold their last values; they are don't-care while `wen_ext`=0.

## Timing
- Reset values:
  - state: IDLE.
  - `s_ready`, `wen_ext`, `ren_ext`, `cpu_enable`, `busy`, `err`: 0.
  - `addr_ext`: BASE_ADDR. `wdata_ext`: 0.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- Latency:
  - `wen_ext` pulses in the cycle after the 4th byte handshake.
  - With `s_valid` held high, throughput is 1 word per 5 cycles.
- `cpu_enable` rises in the cycle after the final WRITE cycle.
- In IDLE, `start` together with `halt`: `halt` wins; stay IDLE with no `err` pulse.
- `s_valid` dropping mid-word: the byte index holds and packing resumes when `s_valid` returns.
- Reset asserted mid-load: outputs return to their reset values immediately (asynchronous). Partially written memory content is left as is.

## Structure
- Shared package `loader_pkg`: state encoding localparams (`LD_IDLE`, `LD_LOAD`, `LD_WRITE`, `LD_RUN`).
- Sub-module `byte_packer`:
  - 4-lane byte register with a 2-bit lane index, `clear` and `load` inputs, `word` and `last_lane` outputs.
  - Built on the `reg_arstn_en` register cell.
- Top FSM, word counter and address register are in `imem_loader`.

## Test plan
- **Basic load:** `start`, `word_count`=2, bytes 11 22 33 44 55 66 77 88 → writes 32'h44332211 @0x0, then 32'h88776655 @0x4; `cpu_enable` rises 1 cycle after the second write.
- **Gappy stream:** same load with `s_valid` low for 3 cycles after each byte → identical writes; `wen_ext` asserted only for 1 cycle per word.
- **Zero count:** `start`, `word_count`=0 → no `wen_ext`; `cpu_enable`=1 on the next cycle.
- **Over-range:** `word_count`=513 → `err` pulses once; state stays IDLE; no writes.
- **Abort:** `halt` after 2 bytes of word 0 → IDLE, no write. A fresh `start`, `word_count`=1, with bytes AA BB CC DD → 32'hDDCCBBAA @0x0.
- **Async reset:** reset during RUN → `cpu_enable` drops without waiting for a clock edge. After release, `start`, `word_count`=1 with BASE_ADDR=0x100 → write @0x100.
